// File: rtl/ysyx_23060111_regfile_sb_if.sv
// Register file / scoreboard port bundle: issue+writeback side drives (master),
// register file responds (slave).
interface ysyx_23060111_regfile_sb_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NR_RD      = 2
);
  logic [NR_RD*ADDR_WIDTH-1:0] raddr;
  logic [NR_RD*DATA_WIDTH-1:0] rdata;
  logic [NR_RD-1:0]            rbusy;
  logic                        wen;
  logic [ADDR_WIDTH-1:0]       waddr;
  logic [DATA_WIDTH-1:0]       wdata;
  logic                        iss_valid;
  logic [ADDR_WIDTH-1:0]       iss_rd;
  logic                        iss_ready;
  logic                        flush;
  logic [ADDR_WIDTH:0]         busy_cnt;

  modport master (
    output raddr, wen, waddr, wdata, iss_valid, iss_rd, flush,
    input  rdata, rbusy, iss_ready, busy_cnt
  );

  modport slave (
    input  raddr, wen, waddr, wdata, iss_valid, iss_rd, flush,
    output rdata, rbusy, iss_ready, busy_cnt
  );
endinterface

// File: rtl/ysyx_23060111_regfile_sb.sv
// GPR file with combinational read ports, one synchronous write port, optional write bypass
// and a per-register busy scoreboard (flush > set > clear) with a registered busy count.
module ysyx_23060111_regfile_sb #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NR_RD      = 2,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1
) (
  input logic                     clk,
  input logic                     rst_n,
  ysyx_23060111_regfile_sb_if.slave bus
);

  localparam int NREG = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);

  logic [DATA_WIDTH-1:0]       rf_q [NREG];
  logic [NREG-1:0]             busy_q, busy_d;
  logic [ADDR_WIDTH:0]         busy_cnt_q, busy_cnt_d;
  logic [NR_RD*DATA_WIDTH-1:0] rdata_w;
  logic [NR_RD-1:0]            rbusy_w;

  logic wr_zero, wr_en, iss_zero, iss_ready_w, fire, set_hit, clr_hit;

  assign wr_zero     = (ZERO_REG != 0) && (bus.waddr == '0);
  assign wr_en       = bus.wen && !wr_zero;
  assign iss_zero    = (ZERO_REG != 0) && (bus.iss_rd == '0);
  assign iss_ready_w = iss_zero || !busy_q[bus.iss_rd];
  assign fire        = bus.iss_valid && iss_ready_w && !bus.flush;
  assign set_hit     = fire && !iss_zero;
  // A reservation landing on the index being written back keeps the new reservation.
  assign clr_hit     = bus.wen && busy_q[bus.waddr] && !(set_hit && (bus.iss_rd == bus.waddr));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (wr_en) begin
      rf_q[bus.waddr] <= bus.wdata;
    end
  end

  for (genvar p = 0; p < NR_RD; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic                  zero_hit, byp_hit;
    assign ra       = bus.raddr[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign zero_hit = (ZERO_REG != 0) && (ra == '0);
    assign byp_hit  = (BYPASS != 0) && bus.wen && (bus.waddr == ra);
    assign rdata_w[p*DATA_WIDTH +: DATA_WIDTH] = zero_hit ? '0 :
                                                 byp_hit  ? bus.wdata : rf_q[ra];
    assign rbusy_w[p] = !zero_hit && busy_q[ra] && !byp_hit;
  end

  always_comb begin
    busy_d     = busy_q;
    busy_cnt_d = busy_cnt_q;
    if (bus.flush) begin
      busy_d     = '0;
      busy_cnt_d = '0;
    end else begin
      if (clr_hit) begin
        busy_d[bus.waddr] = 1'b0;
        busy_cnt_d        = busy_cnt_d - CNT_ONE;
      end
      // iss_ready guarantees the target was idle, so a set is always a 0->1 transition.
      if (set_hit) begin
        busy_d[bus.iss_rd] = 1'b1;
        busy_cnt_d         = busy_cnt_d + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign bus.rdata     = rdata_w;
  assign bus.rbusy     = rbusy_w;
  assign bus.iss_ready = iss_ready_w;
  assign bus.busy_cnt  = busy_cnt_q;

endmodule

// File: tb/tb_ysyx_23060111_regfile_sb.sv
// Randomised + directed bench: driver pushes expected outputs from a behavioural
// register/busy model, a negedge monitor pops and compares.
module tb_ysyx_23060111_regfile_sb;

  logic clk;
  logic rst_n;

  ysyx_23060111_regfile_sb_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NR_RD(2)) bus ();

  ysyx_23060111_regfile_sb #(
    .ADDR_WIDTH(5), .DATA_WIDTH(32), .NR_RD(2), .BYPASS(1), .ZERO_REG(1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  logic [31:0] m_rf   [32];
  bit          m_busy [32];

  function automatic logic [31:0] exp_rdata(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (bus.wen && bus.waddr == a) return bus.wdata;
    return m_rf[a];
  endfunction

  function automatic bit exp_rbusy(input logic [4:0] a);
    if (a == 0) return 1'b0;
    return m_busy[a] && !(bus.wen && bus.waddr == a);
  endfunction

  function automatic int n_busy();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  function automatic bit exp_ready();
    return (bus.iss_rd == 0) || !m_busy[bus.iss_rd];
  endfunction

  task automatic push_all(input string tag);
    logic [4:0] a0, a1;
    a0 = bus.raddr[4:0];
    a1 = bus.raddr[9:5];
    q.push_back('{0, exp_rdata(a0), {tag, ".rdata0"}});
    q.push_back('{1, exp_rdata(a1), {tag, ".rdata1"}});
    q.push_back('{2, {30'h0, exp_rbusy(a1), exp_rbusy(a0)}, {tag, ".rbusy"}});
    q.push_back('{3, {31'h0, exp_ready()}, {tag, ".iss_ready"}});
    q.push_back('{4, 32'(n_busy()), {tag, ".busy_cnt"}});
  endtask

  // Apply the register-file rules for one clock edge with the currently held inputs.
  task automatic model_edge();
    bit fire;
    fire = bus.iss_valid && exp_ready() && !bus.flush;
    if (bus.wen && bus.waddr != 0) m_rf[bus.waddr] = bus.wdata;
    if (bus.flush) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    end else begin
      if (bus.wen) m_busy[bus.waddr] = 1'b0;
      if (fire && bus.iss_rd != 0) m_busy[bus.iss_rd] = 1'b1;
    end
  endtask

  task automatic cyc(input string tag, input logic [4:0] r0, input logic [4:0] r1,
                     input logic we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic iv, input logic [4:0] ird, input logic fl);
    bus.raddr     = {r1, r0};
    bus.wen       = we;
    bus.waddr     = wa;
    bus.wdata     = wd;
    bus.iss_valid = iv;
    bus.iss_rd    = ird;
    bus.flush     = fl;
    push_all(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset(input string tag, input logic [4:0] r0);
    bus.raddr = {5'd0, r0};
    bus.wen = 1'b0; bus.waddr = '0; bus.wdata = '0;
    bus.iss_valid = 1'b0; bus.iss_rd = r0; bus.flush = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 32; i++) begin m_rf[i] = '0; m_busy[i] = 1'b0; end
    push_all(tag);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin : monitor
    chk_t c;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        c = q.pop_front();
        case (c.kind)
          0:       act = bus.rdata[31:0];
          1:       act = bus.rdata[63:32];
          2:       act = {30'h0, bus.rbusy};
          3:       act = {31'h0, bus.iss_ready};
          default: act = {26'h0, bus.busy_cnt};
        endcase
        n_total++;
        if (act === c.exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", c.name, act, c.exp);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : driver
    logic [4:0] a, b, w, r;
    rst_n = 1'b0;
    #1;
    do_reset("init_reset", 5'd5);

    // x0 is never written and never reserved
    cyc("x0_wr",   0, 0, 1, 0, 32'hFFFF_FFFF, 1, 0, 0);
    cyc("x0_chk",  0, 0, 0, 0, 0, 1, 0, 0);

    // RAW with bypass
    cyc("raw_iss", 0, 0, 0, 0, 0, 1, 3, 0);
    cyc("raw_rd",  3, 0, 0, 0, 0, 0, 0, 0);
    cyc("raw_wb",  3, 3, 1, 3, 32'h1234, 0, 0, 0);
    cyc("raw_aft", 3, 0, 0, 0, 0, 0, 0, 0);

    // WAW stall
    cyc("waw_iss1", 0, 0, 0, 0, 0, 1, 7, 0);
    cyc("waw_iss2", 7, 0, 0, 0, 0, 1, 7, 0);
    cyc("waw_wb",   7, 0, 1, 7, 32'h77, 0, 7, 0);
    cyc("waw_aft",  7, 0, 0, 0, 0, 1, 7, 0);
    cyc("waw_clr",  0, 0, 1, 7, 32'h78, 0, 0, 0);

    // writeback and reservation on the same register
    cyc("sim_iss", 0, 0, 0, 0, 0, 1, 9, 0);
    cyc("sim_both", 9, 0, 1, 9, 32'h9999, 1, 9, 0);
    cyc("sim_aft", 9, 0, 0, 0, 0, 0, 9, 0);
    cyc("sim_clr", 9, 0, 1, 9, 32'h9A9A, 0, 0, 0);

    // flush beats concurrent issue, write still lands
    cyc("fl_i1", 0, 0, 0, 0, 0, 1, 1, 0);
    cyc("fl_i2", 0, 0, 0, 0, 0, 1, 2, 0);
    cyc("fl_i4", 1, 2, 0, 0, 0, 1, 4, 0);
    cyc("fl_go", 4, 8, 1, 8, 32'h55, 1, 6, 1);
    cyc("fl_aft", 8, 6, 0, 0, 0, 0, 6, 0);

    n_total++;
    if (bus.rdata[31:0] === 32'h55) n_pass++;
    else $display("FAIL fl_direct.rdata0: got 0x%0h", bus.rdata[31:0]);
    n_total++;
    if (bus.busy_cnt === 6'd0) n_pass++;
    else $display("FAIL fl_direct.busy_cnt: got %0d", bus.busy_cnt);
    n_total++;
    if (bus.rbusy === 2'b00) n_pass++;
    else $display("FAIL fl_direct.rbusy: got 0x%0h", bus.rbusy);

    // mid-run asynchronous reset
    cyc("rst_wr",  0, 0, 1, 5, 32'hDEAD, 1, 11, 0);
    cyc("rst_pre", 5, 11, 0, 0, 0, 0, 0, 0);
    do_reset("mid_reset", 5'd5);

    n_total++;
    if (bus.busy_cnt === 6'd0) n_pass++;
    else $display("FAIL rst_direct.busy_cnt: got %0d", bus.busy_cnt);
    n_total++;
    if (bus.iss_ready === 1'b1) n_pass++;
    else $display("FAIL rst_direct.iss_ready: got %0b", bus.iss_ready);

    cyc("rst_aft", 5, 11, 0, 0, 0, 0, 11, 0);

    for (int i = 0; i < 400; i++) begin
      a = 5'($urandom_range(0, 31));
      b = 5'($urandom_range(0, 31));
      r = 5'($urandom_range(0, 31));
      w = ($urandom_range(0, 1) == 1) ? r : 5'($urandom_range(0, 31));
      cyc("rand", a, b, 1'($urandom_range(0, 1)), w, $urandom,
          1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
          ($urandom_range(0, 31) == 0));
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
